// File: rtl/mul_div_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Multiplies walk the product register right; divides walk left.
    function automatic logic is_mul(input op_t o);
        return (o == OP_MUL) || (o == OP_MULHU);
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: a shift-add multiply step or a restoring
// divide step, selected by the operation.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,      // product high half / partial remainder
    input  logic             bit_i,      // multiplier LSB / next dividend MSB
    input  logic [WIDTH-1:0] operand_i,  // multiplicand / divisor
    input  op_t              op_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             bit_o       // product bit shifted out / quotient bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    // Compute the next accumulator and the bit that enters the low register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        acc_o   = acc_i;
        bit_o   = 1'b0;
        sum     = '0;
        shifted = '0;
        trial   = '0;
        if (is_mul(op_i)) begin
            sum   = {1'b0, acc_i} + (bit_i ? {1'b0, operand_i} : '0);
            acc_o = sum[WIDTH:1];
            bit_o = sum[0];
        end else begin
            // The shifted partial remainder needs WIDTH+1 bits; a successful
            // subtraction always leaves less than the divisor, so WIDTH bits
            // of the difference are exact.
            shifted = {acc_i, bit_i};
            trial   = shifted[WIDTH-1:0] - operand_i;
            if (shifted >= {1'b0, operand_i}) begin
                acc_o = trial;
                bit_o = 1'b1;
            end else begin
                acc_o = shifted[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/unidade_mul_div.sv
// Iterative unsigned multiply/divide execute stage. Takes WIDTH cycles of
// iteration plus one DONE cycle that pulses the register-file write enable.
module unidade_mul_div
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] readA,
    input  logic [WIDTH-1:0] readB,
    input  logic [4:0]       rc,
    output logic             busy,
    output logic [WIDTH-1:0] write,
    output logic [4:0]       rc_out,
    output logic             writeReg
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    op_t              op_q,      op_d;
    logic [WIDTH-1:0] operand_q, operand_d;  // multiplicand or divisor
    logic [WIDTH-1:0] acc_q,     acc_d;      // product high / remainder
    logic [WIDTH-1:0] lo_q,      lo_d;       // multiplier->product low / dividend->quotient
    logic [4:0]       rc_q,      rc_d;
    logic [WIDTH-1:0] write_q,   write_d;
    logic [4:0]       rc_out_q,  rc_out_d;

    logic             step_bit_in;
    logic             step_bit_out;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] lo_next;

    assign step_bit_in = is_mul(op_q) ? lo_q[0] : lo_q[WIDTH-1];
    assign lo_next     = is_mul(op_q) ? {step_bit_out, lo_q[WIDTH-1:1]}
                                      : {lo_q[WIDTH-2:0], step_bit_out};

    mul_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .bit_i     (step_bit_in),
        .operand_i (operand_q),
        .op_i      (op_q),
        .acc_o     (step_acc),
        .bit_o     (step_bit_out)
    );

    // Next-state logic: accept in IDLE, iterate in CALC, publish in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        rc_d      = rc_q;
        write_d   = write_q;
        rc_out_d  = rc_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    op_d    = op_t'(op);
                    cnt_d   = '0;
                    acc_d   = '0;
                    rc_d    = rc;
                    if (is_mul(op_t'(op))) begin
                        operand_d = readA;
                        lo_d      = readB;
                    end else begin
                        operand_d = readB;
                        lo_d      = readA;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                lo_d  = lo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    rc_out_d = rc_q;
                    case (op_q)
                        OP_MULHU, OP_REMU: write_d = step_acc;
                        default:           write_d = lo_next;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and visible outputs, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= '0;
            rc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            rc_out_q <= rc_out_d;
        end
    end

    // Datapath registers, always reloaded before use on each accepted start.
    always_ff @(posedge clock) begin
        // NOTE: these carry no reset; their contents are never observed
        // before IDLE loads them, so a reset here would only add fan-out.
        op_q      <= op_d;
        operand_q <= operand_d;
        acc_q     <= acc_d;
        lo_q      <= lo_d;
        rc_q      <= rc_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign writeReg = (state_q == S_DONE);
    assign write    = write_q;
    assign rc_out   = rc_out_q;

endmodule

// File: tb/tb_unidade_mul_div.sv
// Directed bench for unidade_mul_div with a result scoreboard.
module tb_unidade_mul_div;
    import mul_div_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] readA = '0;
    logic [31:0] readB = '0;
    logic [4:0]  rc    = '0;
    logic        busy;
    logic [31:0] write;
    logic [4:0]  rc_out;
    logic        writeReg;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    int   issue_cyc = 0;
    int   pulses    = 0;
    int   p0;

    unidade_mul_div #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .readA    (readA),
        .readB    (readB),
        .rc       (rc),
        .busy     (busy),
        .write    (write),
        .rc_out   (rc_out),
        .writeReg (writeReg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (writeReg === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one edge and record its expectation.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        exp_t e;
        @(negedge clock);
        issue_cyc = cyc + 1;
        start = 1'b1;
        op    = o;
        readA = a;
        readB = b;
        rc    = r;
        e.data = model(o, a, b);
        e.rc   = r;
        sb.push_back(e);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for the write pulse and compare against the scoreboard.
    task automatic wait_result(input bit poke_done);
        bit   found;
        exp_t e;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (writeReg === 1'b1) found = 1'b1;
        end
        check("pulse_seen", 32'(found), 32'd1);
        if (found) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write", write, e.data);
                check("rc_out", 32'(rc_out), 32'(e.rc));
            end
            check("latency", 32'(cyc - issue_cyc), 32'd32);
            check("busy_in_done", 32'(busy), 32'd1);
            if (poke_done) begin
                start = 1'b1;
                op    = 2'b11;
                readA = 32'h5555_5555;
                readB = 32'h0000_0003;
                rc    = 5'd30;
            end
            @(negedge clock);
            start = 1'b0;
            check("pulse_one_cycle", 32'(writeReg), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        // Reset held together with start: request must be dropped.
        start = 1'b1;
        op    = 2'b00;
        readA = 32'd1;
        readB = 32'd1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_writeReg", 32'(writeReg), 32'd0);
        check("rst_write", write, 32'd0);
        check("rst_rc_out", 32'(rc_out), 32'd0);
        @(negedge clock);
        check("rst_start_dropped", 32'(busy), 32'd0);

        // Basic multiply with timing and hold of registered outputs.
        issue(2'b00, 32'd7, 32'd6, 5'd5);
        wait_result(1'b0);
        repeat (3) @(negedge clock);
        check("write_hold", write, 32'd42);
        check("rc_out_hold", 32'(rc_out), 32'd5);

        // Full-scale operands.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        wait_result(1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_result(1'b0);

        // Division and remainder.
        issue(2'b10, 32'd100, 32'd7, 5'd3);
        wait_result(1'b0);
        issue(2'b11, 32'd100, 32'd7, 5'd4);
        wait_result(1'b0);
        issue(2'b10, 32'h8000_0000, 32'd1, 5'd31);
        wait_result(1'b0);

        // Divide by zero.
        issue(2'b10, 32'h0000_1234, 32'd0, 5'd6);
        wait_result(1'b0);
        issue(2'b11, 32'h0000_1234, 32'd0, 5'd0);
        wait_result(1'b0);

        // start re-pulsed mid-run and in DONE, operands changed mid-run.
        p0 = pulses;
        issue(2'b00, 32'd3, 32'd4, 5'd7);
        repeat (5) @(negedge clock);
        start = 1'b1;
        op    = 2'b10;
        readA = 32'd99;
        readB = 32'd5;
        rc    = 5'd9;
        @(negedge clock);
        start = 1'b0;
        readA = 32'd1234;
        wait_result(1'b1);
        repeat (2) @(negedge clock);
        check("single_pulse", 32'(pulses - p0), 32'd1);
        check("done_start_ignored", 32'(busy), 32'd0);

        // Reset in the middle of a divide.
        issue(2'b10, 32'd1000, 32'd3, 5'd12);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_writeReg", 32'(writeReg), 32'd0);
        check("midrst_write", write, 32'd0);
        check("midrst_rc_out", 32'(rc_out), 32'd0);
        void'(sb.pop_back());
        p0 = pulses;
        repeat (40) @(negedge clock);
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        issue(2'b00, 32'd2, 32'd3, 5'd13);
        wait_result(1'b0);

        // A few random operations across all op codes.
        for (int k = 0; k < 4; k++) begin
            issue(2'(k), $urandom, $urandom_range(1, 32'hFFFF), 5'($urandom_range(0, 31)));
            wait_result(1'b0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
